// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : adder_pkg
//  Description : Shared defaults and the stage-record layout for the
//                pipelined ripple-carry adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

  // Default operand width and pipeline depth for pipelined_adder
  localparam int ADD_WIDTH_DEF  = 16;
  localparam int ADD_STAGES_DEF = 4;

  // One pipeline slot at the default configuration. The top level keeps the
  // same fields per stage, but each stage trims sum_lo/a_hi/b_hi to the bits it
  // actually carries, so no register bit is dead.
  typedef struct packed {
    logic                     valid;
    logic                     carry;
    logic [ADD_WIDTH_DEF-1:0] sum_lo;
    logic [ADD_WIDTH_DEF-1:0] a_hi;
    logic [ADD_WIDTH_DEF-1:0] b_hi;
  } stage_rec_t;

endpackage
`default_nettype wire

// File: rtl/add_chunk.sv
`default_nettype none
// ============================================================================
//  Module      : add_chunk
//  Description : Combinational CHUNK-bit ripple of full-adder cells.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_chunk #(
  parameter int CHUNK = 4
) (
  input  logic             cin,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  // Ripple the carry LSB to MSB through one full-adder cell per bit
  always_comb begin : p_ripple
    logic w_carry;
    s       = '0;
    w_carry = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]    = a[i] ^ b[i] ^ w_carry;
      w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
    end
    cout = w_carry;
  end

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder
//  Description : Pipelined ripple-carry adder, sum = a + b + cin. WIDTH bits
//                are split into STAGES chunks; each stage adds one chunk and
//                registers the carry for the next. Valid/ready on both sides,
//                backpressure stalls the whole pipe.
//                Optional macro PIPELINED_ADDER_OVF_EN builds the signed
//                overflow register; without it ovf is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADD_WIDTH_DEF,
  parameter int STAGES = ADD_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int c_chunk = WIDTH / STAGES;

  if (WIDTH % STAGES != 0) begin : g_chk_div
    $error("pipelined_adder: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
  end
  if (STAGES < 1 || STAGES > WIDTH) begin : g_chk_rng
    $error("pipelined_adder: STAGES (%0d) must lie in 1..WIDTH", STAGES);
  end

  // Whole pipe moves together: only a held result at the output can stop it
  logic w_adv;

  // Upper operand bits still waiting to be summed, carried behind stage k
  for (genvar k = 0; k < STAGES - 1; k++) begin : g_hi
    localparam int c_hw = WIDTH - (k + 1) * c_chunk;
    logic [c_hw-1:0] r_a_hi;
    logic [c_hw-1:0] r_b_hi;

    // Forward the untouched high operand bits with each real op
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_a_hi <= '0;
        r_b_hi <= '0;
      end else if (w_adv && g_stage[k].w_v_in) begin
        r_a_hi <= g_stage[k].w_a_in[WIDTH-k*c_chunk-1:c_chunk];
        r_b_hi <= g_stage[k].w_b_in[WIDTH-k*c_chunk-1:c_chunk];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int c_aw = WIDTH - k * c_chunk;   // operand bits entering stage k
    localparam int c_sw = (k + 1) * c_chunk;     // sum bits known after stage k

    logic [c_aw-1:0]    w_a_in;
    logic [c_aw-1:0]    w_b_in;
    logic               w_c_in;
    logic               w_v_in;
    logic [c_chunk-1:0] w_s;
    logic               w_co;
    logic [c_sw-1:0]    w_sum_nxt;
    logic               r_valid;
    logic               r_carry;
    logic [c_sw-1:0]    r_sum;

    if (k == 0) begin : g_src
      assign w_a_in    = a;
      assign w_b_in    = b;
      assign w_c_in    = cin;
      assign w_v_in    = in_valid;
      assign w_sum_nxt = w_s;
    end else begin : g_src
      assign w_a_in    = g_hi[k-1].r_a_hi;
      assign w_b_in    = g_hi[k-1].r_b_hi;
      assign w_c_in    = g_stage[k-1].r_carry;
      assign w_v_in    = g_stage[k-1].r_valid;
      assign w_sum_nxt = {w_s, g_stage[k-1].r_sum};
    end

    add_chunk #(
      .CHUNK (c_chunk)
    ) u_add (
      .cin  (w_c_in),
      .a    (w_a_in[c_chunk-1:0]),
      .b    (w_b_in[c_chunk-1:0]),
      .s    (w_s),
      .cout (w_co)
    );

    // Slot valid shifts on every advance so bubbles travel as empty slots
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid <= 1'b0;
      end else if (w_adv) begin
        r_valid <= w_v_in;
      end
    end

    // Carry and partial sum load only for real ops; bubbles leave them as-is
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_carry <= 1'b0;
        r_sum   <= '0;
      end else if (w_adv && w_v_in) begin
        r_carry <= w_co;
        r_sum   <= w_sum_nxt;
      end
    end
  end

  assign w_adv     = ~g_stage[STAGES-1].r_valid | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = g_stage[STAGES-1].r_valid;
  assign sum       = g_stage[STAGES-1].r_sum;
  assign cout      = g_stage[STAGES-1].r_carry;

`ifdef PIPELINED_ADDER_OVF_EN
  logic r_ovf;
  logic w_ovf_nxt;

  // Top chunk holds both operand sign bits and the result sign bit
  assign w_ovf_nxt = (g_stage[STAGES-1].w_a_in[c_chunk-1] == g_stage[STAGES-1].w_b_in[c_chunk-1]) &
                     (g_stage[STAGES-1].w_s[c_chunk-1]    != g_stage[STAGES-1].w_a_in[c_chunk-1]);

  // Overflow flag travels with the final stage so it is valid with out_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_adv && g_stage[STAGES-1].w_v_in) begin
      r_ovf <= w_ovf_nxt;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_adder
//  Description : Scoreboard bench for pipelined_adder (16/4 and 4/2 builds).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, cin, cout, ovf;
  logic [W-1:0]  a, b, sum;
  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_cin, s_cout, s_ovf;
  logic [3:0]    s_a, s_b, s_sum;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_adder #(.WIDTH(4), .STAGES(2)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a), .b(s_b),
    .cin(s_cin), .out_valid(s_out_valid), .out_ready(s_out_ready), .sum(s_sum), .cout(s_cout),
    .ovf(s_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t q_m[$];
  exp_t q_s[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   pops_s   = 0;
  bit   lat_en   = 1'b0;
  bit   acc_m    = 1'b0;
  bit   acc_s    = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, req, $time);
    end
  endtask

  function automatic exp_t model_m(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] t;
    exp_t       e;
    t      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.sum  = t[W-1:0];
    e.cout = t[W];
`ifdef PIPELINED_ADDER_OVF_EN
    e.ovf  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
`else
    e.ovf  = 1'b0;
`endif
    e.acc  = cyc;
    return e;
  endfunction

  function automatic exp_t model_s(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] t;
    exp_t       e;
    t      = {1'b0, x} + {1'b0, y} + {4'b0, c};
    e.sum  = {{(W-4){1'b0}}, t[3:0]};
    e.cout = t[4];
`ifdef PIPELINED_ADDER_OVF_EN
    e.ovf  = (x[3] == y[3]) && (t[3] != x[3]);
`else
    e.ovf  = 1'b0;
`endif
    e.acc  = cyc;
    return e;
  endfunction

  // One clock: sample both DUTs at negedge, score outputs, log accepted inputs
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    acc_m = in_valid && in_ready;
    acc_s = s_in_valid && s_in_ready;
    if (out_valid && out_ready) begin
      if (q_m.size() == 0) begin
        check("stale_out", 32'(out_valid), 32'd0);
      end else begin
        e = q_m.pop_front();
        check("sum",  32'(sum),  32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
        check("ovf",  32'(ovf),  32'(e.ovf));
        if (lat_en) check("latency", 32'(cyc - e.acc), 32'(S));
      end
    end
    if (s_out_valid && s_out_ready) begin
      pops_s++;
      if (q_s.size() == 0) begin
        check("small_stale_out", 32'(s_out_valid), 32'd0);
      end else begin
        e = q_s.pop_front();
        check("small_sum",  32'(s_sum),  32'(e.sum));
        check("small_cout", 32'(s_cout), 32'(e.cout));
        check("small_ovf",  32'(s_ovf),  32'(e.ovf));
      end
    end
    if (acc_m) q_m.push_back(model_m(a, b, cin));
    if (acc_s) q_s.push_back(model_s(s_a, s_b, s_cin));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a = x; b = y; cin = c; in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (acc_m) break;
    end
    if (!acc_m) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_s(input logic [3:0] x, input logic [3:0] y, input logic c);
    s_a = x; s_b = y; s_cin = c; s_in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (acc_s) break;
    end
    if (!acc_s) check("small_send_timeout", 32'd0, 32'd1);
    s_in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; s_in_valid = 1'b0; out_ready = 1'b1; s_out_ready = 1'b1;
    for (int i = 0; i < 40 && (q_m.size() != 0 || q_s.size() != 0); i++) tick();
    check("drain_main_empty",  32'(q_m.size()), 32'd0);
    check("drain_small_empty", 32'(q_s.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] snap_sum;
    logic         snap_cout;
    int           c0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_a = '0; s_b = '0; s_cin = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum",       32'(sum),       32'd0);
    check("rst_cout",      32'(cout),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Carry chain across every stage boundary, with fill latency
    lat_en = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0);
    drain();
    send(16'h0000, 16'h0000, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    drain();

    // Signed overflow corner cases
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h8000, 16'hFFFF, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    drain();

    // Streaming: 100 back-to-back random ops, one per cycle
    c0 = cyc;
    for (int i = 0; i < 100; i++) send(W'($urandom), W'($urandom), 1'($urandom));
    check("throughput_cycles", 32'(cyc - c0), 32'd100);
    drain();
    lat_en = 1'b0;

    // Backpressure: stall a full pipe for 5 cycles
    for (int i = 0; i < 4; i++) send(W'($urandom), W'($urandom), 1'($urandom));
    out_ready = 1'b0;
    snap_sum  = sum;
    snap_cout = cout;
    check("bp_full_valid", 32'(out_valid), 32'd1);
    a = 16'h1234; b = 16'hABCD; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_in_ready", 32'(in_ready),  32'd0);
      check("bp_sum",      32'(sum),       32'(snap_sum));
      check("bp_cout",     32'(cout),      32'(snap_cout));
      check("bp_valid",    32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    send(16'h1234, 16'hABCD, 1'b1);
    for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), 1'($urandom));
    drain();

    // Random bubbles and random backpressure together
    in_valid = 1'b0; acc_m = 1'b0;
    for (int i = 0; i < 200; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc_m) begin
        in_valid = 1'($urandom_range(0, 1));
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      tick();
    end
    drain();

    // Reset with ops in flight flushes everything
    for (int i = 0; i < 4; i++) send(W'($urandom), W'($urandom), 1'($urandom));
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_sum",   32'(sum),       32'(q_m[0].sum));
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum",       32'(sum),       32'd0);
    check("midrst_cout",      32'(cout),      32'd0);
    check("midrst_ovf",       32'(ovf),       32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    q_m.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
      check("post_rst_in_ready", 32'(in_ready),  32'd1);
    end

    // Exhaustive WIDTH=4, STAGES=2
    pops_s = 0;
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      send_s(v[3:0], v[7:4], v[8]);
    end
    drain();
    check("small_result_count", 32'(pops_s), 32'd512);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
